bbus_src_reg: RTL and testbench
===============================

# bbus_src_reg

Parametrised, registered successor to the processor's B-bus source selector. It selects one of up to 2**SEL_W word sources by encoded flag and captures the word into an output register. The result is offered to the ALU B input with a valid/ready handshake. An idle select holds the last bus value rather than floating, out-of-range selects raise a sticky error, and completed transfers are counted.

## Interface
- WIDTH, 16, bus word width in bits.
- SEL_W, 3, select-code width.
- NSRC, 8, number of select codes in use, including idle code 0; 2 <= NSRC <= 2**SEL_W. Codes 1..NSRC-1 are sources.
- CNT_W, 16, transfer-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- b_flag  in  SEL_W  source select code.
- b_valid  in  1  select strobe; b_flag is meaningful only while high.
- b_ready  out  1  select accepted this cycle when b_valid & b_ready.
- src_bus  in  NSRC*WIDTH  flattened sources; slice k = src_bus[k*WIDTH +: WIDTH]; slice 0 unused.
- B_bus  out  WIDTH  registered bus word.
- B_valid  out  1  B_bus holds an untaken word.
- B_ready  in  1  consumer accepts B_bus when B_valid & B_ready.
- sel_err  out  1  sticky: an out-of-range code was accepted.
- xfer_cnt  out  CNT_W  count of completed output handshakes.

## Operation
- b_ready = ~B_valid | B_ready. This is combinational and gives a single-entry pipeline register with no bubble under continuous flow.
- Accept = b_valid & b_ready. On accept, decode b_flag:
  - 1..NSRC-1: B_bus <= slice[b_flag]; B_valid <= 1. Sources are sampled in the accept cycle only.
  - 0 (idle): B_valid <= 0; B_bus holds its last value (bus keeper; never Z).
  - >= NSRC: B_valid <= 0; B_bus holds; sel_err <= 1.
- No accept while B_valid & B_ready: B_valid <= 0; B_bus holds.
- No accept while B_valid & ~B_ready: all state holds. B_bus must not change while B_valid is high and the word is untaken.
- xfer_cnt increments by 1 on each cycle with B_valid & B_ready. It wraps from 2**CNT_W-1 to 0.
- sel_err clears only on rst.
- Output-side and input-side handshakes in the same cycle are allowed. The counter increments, and the new word loads with B_valid staying 1.

## Timing
- Reset values: B_bus = 0, B_valid = 0, sel_err = 0, xfer_cnt = 0. b_ready = 1 in the first cycle after reset.
- Latency: a select accepted in cycle N presents B_bus/B_valid from cycle N+1.
- Throughput: one word per cycle while B_ready stays high.
- Backpressure: with B_ready low and B_valid high, b_ready = 0 and b_valid is ignored. The upstream must hold b_flag until accepted.
- Reset mid-transfer: an untaken word is discarded (B_valid = 0 next cycle) and the counter is not incremented. rst has priority over all other updates.
- An out-of-range code accepted in cycle N sets sel_err from cycle N+1.

## Configuration
- BBUS_ZERO_IDLE_EN:
  - Defined: an accepted idle code (0) or out-of-range code loads B_bus <= 0.
  - Undefined: B_bus holds its last value (keeper behaviour).
  - B_valid, sel_err and xfer_cnt behaviour is identical either way.

## Test plan
- Reset, then b_flag=3, b_valid=1, slice3=16'h1234, B_ready=1 -> B_bus=16'h1234, B_valid=1 next cycle; xfer_cnt=1 the cycle after.
- Back-to-back codes 1,2,3 with B_ready=1 -> three consecutive valid words, no bubbles, xfer_cnt=3.
- Load code 5 (16'hBEEF), hold B_ready=0 for 4 cycles while changing slice5 and b_flag -> B_bus stays 16'hBEEF, b_ready=0, count unchanged. Raise B_ready -> count +1.
- Idle code 0 after word 16'hA5A5 -> B_valid=0. B_bus=16'hA5A5 without the macro; 16'h0000 with BBUS_ZERO_IDLE_EN.
- NSRC=6, code 7 -> sel_err=1 next cycle, B_valid=0. Then code 2 -> valid transfer with sel_err still 1. Then rst -> all outputs 0.
- CNT_W=4: 17 transfers -> xfer_cnt wraps to 1. Assert rst while B_valid=1 and B_ready=0 -> B_valid=0, xfer_cnt=0.

Source files
------------

// File: rtl/bbus_src_reg.sv
// Registered B-bus source selector with valid/ready output stage, sticky select error and
// transfer counter. Define BBUS_ZERO_IDLE_EN to clear B_bus on idle/out-of-range selects.
module bbus_src_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned NSRC  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      b_flag,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  output logic [WIDTH-1:0]      B_bus,
  output logic                  B_valid,
  input  logic                  B_ready,
  output logic                  sel_err,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam logic [SEL_W:0] NSRC_EXT = (SEL_W + 1)'(NSRC);

  logic             accept;
  logic             code_oor;
  logic             code_src;
  logic [WIDTH-1:0] sel_word;
  logic             unused_slice0;

  // Slice 0 belongs to the idle code and never reaches the bus.
  assign unused_slice0 = ^src_bus[WIDTH-1:0];

  // Free slot or slot being drained this cycle: no bubble under continuous flow.
  assign b_ready  = ~B_valid | B_ready;
  assign accept   = b_valid & b_ready;
  assign code_oor = {1'b0, b_flag} >= NSRC_EXT;
  assign code_src = (b_flag != '0) & ~code_oor;

  always_comb begin
    sel_word = '0;
    for (int unsigned k = 1; k < NSRC; k++) begin
      if (b_flag == SEL_W'(k)) begin
        sel_word = src_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      B_bus    <= '0;
      B_valid  <= 1'b0;
      sel_err  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      if (B_valid && B_ready) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (accept) begin
        if (code_src) begin
          B_bus   <= sel_word;
          B_valid <= 1'b1;
        end else begin
          B_valid <= 1'b0;
          if (code_oor) begin
            sel_err <= 1'b1;
          end
`ifdef BBUS_ZERO_IDLE_EN
          B_bus <= '0;
`endif
        end
      end else if (B_ready) begin
        B_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bbus_src_reg.sv
// Self-checking bench for bbus_src_reg: directed test-plan steps followed by random traffic,
// all checked against a transaction-level model of the select/handshake rules.
module tb_bbus_src_reg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned NSRC  = 6;
  localparam int unsigned CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [SEL_W-1:0]      b_flag;
  logic                  b_valid;
  logic                  b_ready;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [WIDTH-1:0]      B_bus;
  logic                  B_valid;
  logic                  B_ready;
  logic                  sel_err;
  logic [CNT_W-1:0]      xfer_cnt;

  logic [WIDTH-1:0] src [NSRC];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < int'(NSRC); k++) src_bus[k*WIDTH +: WIDTH] = src[k];
  end

  bbus_src_reg #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W),
    .NSRC (NSRC),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .b_flag  (b_flag),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .src_bus (src_bus),
    .B_bus   (B_bus),
    .B_valid (B_valid),
    .B_ready (B_ready),
    .sel_err (sel_err),
    .xfer_cnt(xfer_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the word on offer, whether it is untaken, error flag, count.
  int m_bus   = 0;
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;
  int m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the combinational ready, advance the model, then check registered outputs.
  task automatic step();
    bit take;
    int fl;
    #1;
    chk("b_ready", 32'(b_ready), 32'((!m_valid || B_ready) ? 1 : 0));
    @(posedge clk);
    fl   = int'(b_flag);
    take = b_valid && (!m_valid || B_ready);
    if (rst) begin
      m_bus = 0; m_valid = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (m_valid && B_ready) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (take) begin
        if (fl >= 1 && fl < int'(NSRC)) begin
          m_bus   = int'(src[fl]);
          m_valid = 1;
        end else begin
          m_valid = 0;
          if (fl >= int'(NSRC)) m_err = 1;
`ifdef BBUS_ZERO_IDLE_EN
          m_bus = 0;
`endif
        end
      end else if (m_valid && B_ready) begin
        m_valid = 0;
      end
    end
    #1;
    chk("B_bus", 32'(B_bus), 32'(m_bus));
    chk("B_valid", 32'(B_valid), 32'(m_valid));
    chk("sel_err", 32'(sel_err), 32'(m_err));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit v, input int fl, input bit rdy);
    b_valid = v;
    b_flag  = SEL_W'(fl);
    B_ready = rdy;
  endtask

  initial begin
    for (int k = 0; k < int'(NSRC); k++) src[k] = WIDTH'(16'h1000 + k);
    rst = 1'b1;
    drive(0, 0, 0);
    step();
    step();
    rst = 1'b0;
    chk("reset_bus", 32'(B_bus), 32'h0);
    chk("reset_cnt", 32'(xfer_cnt), 32'h0);

    // Single transfer through code 3.
    src[3] = 16'h1234;
    drive(1, 3, 1);
    step();
    chk("load_1234", 32'(B_bus), 32'h1234);
    chk("load_valid", 32'(B_valid), 32'h1);
    drive(0, 0, 1);
    step();
    chk("cnt_after_one", 32'(xfer_cnt), 32'h1);

    // Back-to-back codes 1,2,3.
    for (int c = 1; c <= 3; c++) begin
      drive(1, c, 1);
      step();
      chk("b2b_valid", 32'(B_valid), 32'h1);
      chk("b2b_word", 32'(B_bus), 32'(src[c]));
    end
    drive(0, 0, 1);
    step();
    chk("b2b_cnt", 32'(xfer_cnt), 32'h4);

    // Backpressure: word must hold while source and flag change.
    src[5] = 16'hBEEF;
    drive(1, 5, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      src[5] = WIDTH'($urandom);
      drive(1, i, 0);
      step();
      chk("bp_hold", 32'(B_bus), 32'hBEEF);
      chk("bp_ready", 32'(b_ready), 32'h0);
      chk("bp_cnt", 32'(xfer_cnt), 32'h4);
    end
    drive(0, 0, 1);
    step();
    chk("bp_release_cnt", 32'(xfer_cnt), 32'h5);

    // Idle code after a word.
    src[4] = 16'hA5A5;
    drive(1, 4, 1);
    step();
    drive(1, 0, 1);
    step();
    chk("idle_valid", 32'(B_valid), 32'h0);
`ifdef BBUS_ZERO_IDLE_EN
    chk("idle_bus", 32'(B_bus), 32'h0);
`else
    chk("idle_bus", 32'(B_bus), 32'hA5A5);
`endif

    // Out-of-range code 7, then a valid transfer, then reset.
    drive(1, 7, 1);
    step();
    chk("oor_err", 32'(sel_err), 32'h1);
    chk("oor_valid", 32'(B_valid), 32'h0);
    drive(1, 2, 1);
    step();
    chk("err_sticky", 32'(sel_err), 32'h1);
    chk("after_err_word", 32'(B_bus), 32'(src[2]));
    drive(0, 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_err", 32'(sel_err), 32'h0);
    chk("rst_bus", 32'(B_bus), 32'h0);

    // Seventeen transfers wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      drive(1, 1 + (i % 5), 1);
      step();
    end
    drive(0, 0, 1);
    step();
    chk("cnt_wrap", 32'(xfer_cnt), 32'h1);

    // Reset while a word is stalled.
    drive(1, 2, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_stall_valid", 32'(B_valid), 32'h0);
    chk("rst_stall_cnt", 32'(xfer_cnt), 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < int'(NSRC); k++) src[k] = WIDTH'($urandom);
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) != 0));
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
